reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 19 +
 rtl/reset_sequencer_if.sv | 25 ++
 rtl/reset_sequencer_lock_filter.sv | 37 +++
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        WAIT_RDY  = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_e;

    // Bits needed for a counter whose largest value is n-1 (never below 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side signal bundle of the reset sequencer; master is the sequencer itself.
interface reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 4
) ();
    import reset_seq_pkg::*;

    logic                  pll_locked;
    logic [NUM_STAGES-1:0] stage_ready;
    logic                  sw_reset_req;
    logic [NUM_STAGES-1:0] resetn_out;
    logic                  all_ready;
    logic                  fault;
    logic [STATE_W-1:0]    state_o;

    modport master (
        input  pll_locked, stage_ready, sw_reset_req,
        output resetn_out, all_ready, fault, state_o
    );

    modport slave (
        output pll_locked, stage_ready, sw_reset_req,
        input  resetn_out, all_ready, fault, state_o
    );

endinterface

// File: rtl/reset_sequencer_lock_filter.sv
// Consecutive-high filter on PLL lock; flags the cycle the run reaches LOCK_FILTER.
module lock_filter
    import reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_FILTER = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic pll_locked_i,
    output logic locked_c_o
);

    localparam int unsigned         CNT_W    = cnt_width(LOCK_FILTER);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(LOCK_FILTER - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign locked_c_o = en_i && pll_locked_i && (cnt_q == CNT_LAST);

    // Any gap in lock, or leaving the lock-wait state, restarts the run.
    always_comb begin
        cnt_d = '0;
        if (en_i && pll_locked_i && !locked_c_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: filtered PLL lock, then in-order release of NUM_STAGES domains.
// Optional RESET_SEQ_TIMEOUT_EN adds a ready timeout with a sticky fault state.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = 4,
    parameter int unsigned HOLD_CYCLES   = 200,
    parameter int unsigned LOCK_FILTER   = 16,
    parameter int unsigned READY_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.master bus
);

    localparam int unsigned          IDX_W     = cnt_width(NUM_STAGES);
    localparam int unsigned          HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || HOLD_CYCLES < 1 ||
        LOCK_FILTER < 1 || READY_TIMEOUT < 1) begin : g_bad_params
        $error("reset_sequencer: parameter out of range");
    end

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [NUM_STAGES-1:0] resetn_q, resetn_d;
    logic                  all_ready_q, all_ready_d;

    logic locked_c;
    logic cur_ready_c;
    logic fault_hold_c;
    logic restart_c;
    logic timeout_c;

    lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk          (clk),
        .reset        (reset),
        .en_i         (state_q == WAIT_LOCK),
        .pll_locked_i (bus.pll_locked),
        .locked_c_o   (locked_c)
    );

    assign cur_ready_c  = bus.stage_ready[idx_q];
    // Lock loss outranks the software request, and in FAULT it pins the state.
    assign fault_hold_c = (state_q == FAULT) && !bus.pll_locked;
    assign restart_c    = (state_q != WAIT_LOCK) && !fault_hold_c &&
                          (!bus.pll_locked || bus.sw_reset_req);

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam int unsigned      TO_W    = cnt_width(READY_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(READY_TIMEOUT - 1);

    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            fault_q, fault_d;

    assign timeout_c = (state_q == WAIT_RDY) && !cur_ready_c && (tcnt_q == TO_LAST);

    // Timeout counter is zero outside WAIT_RDY, so entry always starts from 0.
    always_comb begin
        tcnt_d  = '0;
        fault_d = fault_q;
        if (restart_c) begin
            fault_d = 1'b0;
        end else if (timeout_c) begin
            fault_d = 1'b1;
        end else if (state_q == WAIT_RDY && !cur_ready_c) begin
            tcnt_d = tcnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            fault_q <= fault_d;
        end
    end

    assign bus.fault = fault_q;
`else
    assign timeout_c = 1'b0;
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_LOCK;
            idx_q       <= '0;
            hold_q      <= '0;
            resetn_q    <= '0;
            all_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            resetn_q    <= resetn_d;
            all_ready_q <= all_ready_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        if (restart_c) begin
            state_d = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: if (locked_c) state_d = HOLD;
                HOLD:      if (hold_q == '0) state_d = WAIT_RDY;
                WAIT_RDY: begin
                    if (cur_ready_c) begin
                        state_d = (idx_q == LAST_IDX) ? RUN : HOLD;
                    end else if (timeout_c) begin
                        state_d = FAULT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage index, hold countdown and registered reset outputs.
    always_comb begin
        idx_d       = idx_q;
        hold_d      = hold_q;
        resetn_d    = resetn_q;
        all_ready_d = all_ready_q;
        if (restart_c) begin
            idx_d       = '0;
            hold_d      = '0;
            resetn_d    = '0;
            all_ready_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (locked_c) begin
                        idx_d  = '0;
                        hold_d = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        resetn_d[idx_q] = 1'b1;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                WAIT_RDY: begin
                    if (cur_ready_c) begin
                        if (idx_q == LAST_IDX) begin
                            all_ready_d = 1'b1;
                        end else begin
                            idx_d  = idx_q + IDX_W'(1);
                            hold_d = HOLD_LOAD;
                        end
                    end else if (timeout_c) begin
                        resetn_d    = '0;
                        all_ready_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resetn_out = resetn_q;
    assign bus.all_ready  = all_ready_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_STAGES=3, HOLD=4, LOCK_FILTER=2, TIMEOUT=8.
module tb_reset_sequencer;

    localparam int unsigned NS = 3;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

    reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

    reset_sequencer #(
        .NUM_STAGES    (NS),
        .HOLD_CYCLES   (4),
        .LOCK_FILTER   (2),
        .READY_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic goto(input int target);
        while (edge_n < target) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] rn, input logic ar,
                              input logic [2:0] st);
        check({tag, ".resetn"}, 32'(bus.resetn_out), 32'(rn));
        check({tag, ".all_ready"}, 32'(bus.all_ready), 32'(ar));
        check({tag, ".state"}, 32'(bus.state_o), 32'(st));
    endtask

    // Hold reset for two edges, check the reset state, then restart edge counting.
    task automatic do_reset();
        reset            = 1'b1;
        bus.pll_locked   = 1'b0;
        bus.stage_ready  = '0;
        bus.sw_reset_req = 1'b0;
        tick();
        tick();
        check_outs("reset", 3'b000, 1'b0, 3'd0);
        check("reset.fault", 32'(bus.fault), 32'd0);
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        // Scenario 1: nominal sequence.
        do_reset();
        bus.pll_locked  = 1'b1;
        bus.stage_ready = 3'b111;
        goto(1);  check_outs("s1.e1", 3'b000, 1'b0, 3'd0);
        goto(2);  check_outs("s1.e2", 3'b000, 1'b0, 3'd1);
        goto(5);  check_outs("s1.e5", 3'b000, 1'b0, 3'd1);
        goto(6);  check_outs("s1.e6", 3'b001, 1'b0, 3'd2);
        goto(10); check_outs("s1.e10", 3'b001, 1'b0, 3'd1);
        goto(11); check_outs("s1.e11", 3'b011, 1'b0, 3'd2);
        goto(16); check_outs("s1.e16", 3'b111, 1'b0, 3'd2);
        goto(17); check_outs("s1.e17", 3'b111, 1'b1, 3'd3);
        check("s1.fault", 32'(bus.fault), 32'd0);

        // Scenario 3: one-cycle lock drop in RUN, then replay.
        bus.pll_locked = 1'b0;
        goto(18); check_outs("s3.drop", 3'b000, 1'b0, 3'd0);
        bus.pll_locked = 1'b1;
        goto(23); check_outs("s3.e23", 3'b000, 1'b0, 3'd1);
        goto(24); check_outs("s3.e24", 3'b001, 1'b0, 3'd2);
        goto(29); check_outs("s3.e29", 3'b011, 1'b0, 3'd2);
        goto(34); check_outs("s3.e34", 3'b111, 1'b0, 3'd2);
        goto(35); check_outs("s3.e35", 3'b111, 1'b1, 3'd3);

        // Ready deassertion in RUN is ignored.
        bus.stage_ready = 3'b000;
        goto(37); check_outs("run.rdy_drop", 3'b111, 1'b1, 3'd3);
        bus.stage_ready = 3'b111;

        // Scenario 5a: software request in RUN.
        bus.sw_reset_req = 1'b1;
        goto(38); check_outs("s5.sw", 3'b000, 1'b0, 3'd0);
        bus.sw_reset_req = 1'b0;
        goto(44); check_outs("s5.e44", 3'b001, 1'b0, 3'd2);
        goto(55); check_outs("s5.e55", 3'b111, 1'b1, 3'd3);

        // Scenario 5b: software request together with lock loss.
        bus.sw_reset_req = 1'b1;
        bus.pll_locked   = 1'b0;
        goto(56); check_outs("s5.both", 3'b000, 1'b0, 3'd0);
        // Request held in WAIT_LOCK must not disturb the lock filter.
        bus.pll_locked = 1'b1;
        goto(58); check_outs("s5.wl_ignore", 3'b000, 1'b0, 3'd1);
        bus.sw_reset_req = 1'b0;
        goto(62); check_outs("s5.e62", 3'b001, 1'b0, 3'd2);
        goto(73); check_outs("s5.e73", 3'b111, 1'b1, 3'd3);

        // Scenario 2: lock glitch restarts the filter.
        do_reset();
        bus.pll_locked  = 1'b1;
        bus.stage_ready = 3'b111;
        goto(1); bus.pll_locked = 1'b0;
        goto(2); bus.pll_locked = 1'b1;
        goto(3); check_outs("s2.e3", 3'b000, 1'b0, 3'd0);
        goto(4); check_outs("s2.e4", 3'b000, 1'b0, 3'd1);
        goto(7); check_outs("s2.e7", 3'b000, 1'b0, 3'd1);
        goto(8); check_outs("s2.e8", 3'b001, 1'b0, 3'd2);

`ifndef RESET_SEQ_TIMEOUT_EN
        // Scenario 4: stage 1 slow to report ready.
        do_reset();
        bus.pll_locked  = 1'b1;
        bus.stage_ready = 3'b101;
        goto(11); check_outs("s4.e11", 3'b011, 1'b0, 3'd2);
        goto(31); check_outs("s4.e31", 3'b011, 1'b0, 3'd2);
        check("s4.fault", 32'(bus.fault), 32'd0);
        bus.stage_ready = 3'b111;
        goto(35); check_outs("s4.e35", 3'b011, 1'b0, 3'd1);
        goto(36); check_outs("s4.e36", 3'b111, 1'b0, 3'd2);
        goto(37); check_outs("s4.e37", 3'b111, 1'b1, 3'd3);
`else
        // Scenario 6: stage 1 never ready, timeout to FAULT.
        do_reset();
        bus.pll_locked  = 1'b1;
        bus.stage_ready = 3'b101;
        goto(11); check_outs("s6.e11", 3'b011, 1'b0, 3'd2);
        goto(18); check_outs("s6.e18", 3'b011, 1'b0, 3'd2);
        check("s6.e18.fault", 32'(bus.fault), 32'd0);
        goto(19); check_outs("s6.e19", 3'b000, 1'b0, 3'd4);
        check("s6.e19.fault", 32'(bus.fault), 32'd1);
        bus.pll_locked = 1'b0;
        goto(21); check_outs("s6.lockloss", 3'b000, 1'b0, 3'd4);
        check("s6.lockloss.fault", 32'(bus.fault), 32'd1);
        bus.pll_locked = 1'b1;
        goto(23); check("s6.sticky", 32'(bus.fault), 32'd1);
        bus.sw_reset_req = 1'b1;
        goto(24); check_outs("s6.sw", 3'b000, 1'b0, 3'd0);
        check("s6.sw.fault", 32'(bus.fault), 32'd0);
        bus.sw_reset_req = 1'b0;
        bus.stage_ready  = 3'b111;
        goto(30); check_outs("s6.e30", 3'b001, 1'b0, 3'd2);
`endif

        // Reset mid-sequence wins over everything.
        do_reset();
        bus.pll_locked  = 1'b1;
        bus.stage_ready = 3'b111;
        goto(11); check_outs("mid.e11", 3'b011, 1'b0, 3'd2);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
